// File: rtl/i2s_rx_if.sv
// Host-side bus of the I2S receiver: I2S pins, run/format controls and FIFO read port.
// "slave" is the receiver's view, "master" is the controlling host / testbench view.
interface i2s_rx_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LVL_W  = 5;
  localparam int unsigned PRE_W  = 8;

  logic              en;
  logic              sck;
  logic              ws;
  logic              sdi;
  logic              sdo;
  logic [PRE_W-1:0]  sck_prescaler;
  logic [4:0]        sample_size;
  logic [1:0]        channels;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic [LVL_W-1:0]  fifo_level_threshold;
  logic              fifo_level_above;
  logic              fifo_full;

  modport master (
    output en, sdi, sck_prescaler, sample_size, channels, fifo_rd, fifo_level_threshold,
    input  sck, ws, sdo, fifo_rdata, fifo_level, fifo_level_above, fifo_full
  );

  modport slave (
    input  en, sdi, sck_prescaler, sample_size, channels, fifo_rd, fifo_level_threshold,
    output sck, ws, sdo, fifo_rdata, fifo_level, fifo_level_above, fifo_full
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S bus-master receiver with a 16 x 32 first-word-fall-through FIFO.
// Define I2S_RX_SIGN_EXTEND_EN to sign-extend captured words instead of zero-filling.
module i2s_rx (
  input logic     clk,
  input logic     rst,
  i2s_rx_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PTR_W  = 4;
  localparam int unsigned LVL_W  = 5;
  localparam int unsigned PRE_W  = 8;
  localparam int unsigned CNT_W  = 6;

  logic [PRE_W-1:0]  pre_cnt;
  logic              sck_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic              pend_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_nxt;
  logic [LVL_W-1:0]  level_q;
  logic              full_q;
  logic              above_q;
  logic [DATA_W-1:0] rdata_q;

  logic              tick;
  logic              sck_rise;
  logic              sck_fall;
  logic [4:0]        pos;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] word;
  logic              do_push;
  logic              do_pop;
  logic [LVL_W-1:0]  level_d;
  logic [DATA_W-1:0] rdata_d;

  assign tick     = (pre_cnt == bus.sck_prescaler);
  assign sck_rise = tick && !sck_q;
  assign sck_fall = tick && sck_q;
  assign pos      = bit_cnt[4:0];
  assign rd_nxt   = rd_ptr + PTR_W'(1);

  assign bus.sck              = sck_q;
  assign bus.ws               = bit_cnt[CNT_W-1];
  assign bus.sdo              = 1'b0;
  assign bus.fifo_rdata       = rdata_q;
  assign bus.fifo_level       = level_q;
  assign bus.fifo_full        = full_q;
  assign bus.fifo_level_above = above_q;

  // Bit clock generation, slot counter and serial capture.
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      pre_cnt <= '0;
      sck_q   <= 1'b0;
      bit_cnt <= '0;
      shift_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        sck_q   <= !sck_q;
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
      if (sck_fall) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (sck_rise && (pos != 5'd0) && (pos <= bus.sample_size)) begin
        shift_q <= {shift_q[DATA_W-2:0], bus.sdi};
      end
      // Flag a completed slot; the push itself happens on the following clk.
      pend_q <= sck_rise && (bus.sample_size != 5'd0) && (pos == bus.sample_size)
                && bus.channels[bit_cnt[CNT_W-1]];
    end
  end

  // Word formatting and FIFO next-state; rdata tracks the next head so it stays registered.
  always_comb begin
    mask = (DATA_W'(1) << bus.sample_size) - DATA_W'(1);
    word = shift_q & mask;
`ifdef I2S_RX_SIGN_EXTEND_EN
    if (shift_q[bus.sample_size - 5'd1]) begin
      word = word | ~mask;
    end
`endif
    do_pop  = bus.fifo_rd && (level_q != '0);
    do_push = pend_q && (!full_q || do_pop);
    level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    rdata_d = rdata_q;
    if (do_pop) begin
      if (level_q == LVL_W'(1)) begin
        rdata_d = do_push ? word : '0;
      end else begin
        rdata_d = mem[rd_nxt];
      end
    end else if (do_push && (level_q == '0)) begin
      rdata_d = word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      above_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_nxt;
      end
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(DEPTH));
      above_q <= (level_d > bus.fifo_level_threshold);
      rdata_q <= rdata_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= word;
    end
  end
endmodule

// File: tb/tb_i2s_rx.sv
// Directed self-checking bench for i2s_rx with a behavioural I2S microphone.
// Expected words follow I2S_RX_SIGN_EXTEND_EN when the bench is built with it.
module tb_i2s_rx;
  logic clk = 1'b0;
  logic rst;
  i2s_rx_if bus ();

  i2s_rx dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef I2S_RX_SIGN_EXTEND_EN
  localparam logic [31:0] EXP_L = 32'hFFFEA5A5;
`else
  localparam logic [31:0] EXP_L = 32'h0002A5A5;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int mic_bits = 0;
  int mode = 0;
  int mic_p;
  int mic_sz;
  logic [31:0] mic_w;

  int   n;
  int   s;
  bit   fell;
  bit   got;
  logic prev_sck;

  function automatic logic [31:0] mic_word(input int slot);
    if (mode == 0) return (slot % 2 == 0) ? 32'h0002A5A5 : 32'h0001FFFF;
    return 32'((48 + 7 * slot) & 255);
  endfunction

  // Expected FIFO word for slot k in mode 1 (8-bit samples, both channels).
  function automatic logic [31:0] exp8(input int k);
    logic [31:0] w;
    w = 32'((48 + 7 * k) & 255);
`ifdef I2S_RX_SIGN_EXTEND_EN
    if (w[7]) w = w | 32'hFFFFFF00;
`endif
    return w;
  endfunction

  // Microphone: shifts a word MSB first, changing sdi on sck falls.
  initial forever begin
    @(negedge bus.sck or posedge rst or negedge bus.en);
    if (rst || !bus.en) begin
      mic_bits = 0;
      bus.sdi  = 1'b0;
    end else begin
      mic_bits = mic_bits + 1;
      mic_p    = mic_bits % 32;
      mic_sz   = int'(bus.sample_size);
      mic_w    = mic_word(mic_bits / 32);
      bus.sdi  = (mic_p >= 1 && mic_p <= mic_sz) ? mic_w[mic_sz - mic_p] : 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pop();
    bus.fifo_rd = 1'b1;
    @(negedge clk);
    bus.fifo_rd = 1'b0;
  endtask

  task automatic wait_level(input string tag, input int lvl, input int limit, output int cyc);
    cyc = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (int'(bus.fifo_level) == lvl) begin
        cyc = i;
        break;
      end
    end
    check(tag, 32'(bus.fifo_level), 32'(lvl));
  endtask

  task automatic wait_rise(input bit use_ws, input int limit, output int cyc, output bit sck_fell);
    logic prev, cur, sprev;
    prev     = use_ws ? bus.ws : bus.sck;
    sprev    = bus.sck;
    cyc      = 0;
    sck_fell = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      cur = use_ws ? bus.ws : bus.sck;
      if (!prev && cur) begin
        cyc      = i;
        sck_fell = sprev && !bus.sck;
        break;
      end
      prev  = cur;
      sprev = bus.sck;
    end
    check(use_ws ? "ws rise seen" : "sck rise seen", 32'(cyc != 0), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " sck"},   32'(bus.sck), 32'd0);
    check({tag, " ws"},    32'(bus.ws), 32'd0);
    check({tag, " sdo"},   32'(bus.sdo), 32'd0);
    check({tag, " level"}, 32'(bus.fifo_level), 32'd0);
    check({tag, " full"},  32'(bus.fifo_full), 32'd0);
    check({tag, " above"}, 32'(bus.fifo_level_above), 32'd0);
    check({tag, " rdata"}, bus.fifo_rdata, 32'd0);
  endtask

  initial begin
    rst                      = 1'b1;
    bus.en                   = 1'b1;
    bus.fifo_rd              = 1'b0;
    bus.sck_prescaler        = 8'd4;
    bus.sample_size          = 5'd18;
    bus.channels             = 2'b01;
    bus.fifo_level_threshold = 5'd5;
    mode                     = 0;

    // Reset state and clock timing.
    do_reset();
    check_idle_outputs("reset");
    wait_rise(1'b0, 100, n, fell);
    check("first sck rise", 32'(n), 32'd5);
    wait_rise(1'b0, 100, n, fell);
    check("sck period", 32'(n), 32'd10);
    wait_rise(1'b1, 1000, n, fell);
    wait_rise(1'b1, 1000, n, fell);
    check("ws period", 32'(n), 32'd640);
    check("ws on sck fall", 32'(fell), 32'd1);

    // Left-only 18-bit capture.
    do_reset();
    wait_level("left push", 1, 1000, n);
    check("push latency", 32'(n), 32'd186);
    check("left word", bus.fifo_rdata, EXP_L);
    repeat (400) @(negedge clk);
    check("right dropped", 32'(bus.fifo_level), 32'd1);
    pop();
    check("pop level", 32'(bus.fifo_level), 32'd0);
    check("empty rdata", bus.fifo_rdata, 32'd0);
    pop();
    check("rd empty level", 32'(bus.fifo_level), 32'd0);
    check("rd empty rdata", bus.fifo_rdata, 32'd0);

    // Threshold and ordered pops, both channels, 8-bit samples.
    mode            = 1;
    bus.channels    = 2'b11;
    bus.sample_size = 5'd8;
    do_reset();
    wait_level("level 5", 5, 3000, n);
    check("above at 5", 32'(bus.fifo_level_above), 32'd0);
    wait_level("level 6", 6, 1000, n);
    check("above at 6", 32'(bus.fifo_level_above), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("pop order", bus.fifo_rdata, exp8(k));
      pop();
    end
    check("level after 5 pops", 32'(bus.fifo_level), 32'd1);
    check("above after pops", 32'(bus.fifo_level_above), 32'd0);
    check("head after pops", bus.fifo_rdata, exp8(5));

    // Fill to full, overflow drops, push+pop while full.
    do_reset();
    wait_level("fill", 16, 8000, n);
    check("full flag", 32'(bus.fifo_full), 32'd1);
    check("full head", bus.fifo_rdata, exp8(0));
    repeat (1300) @(negedge clk);
    check("overflow level", 32'(bus.fifo_level), 32'd16);
    check("overflow head", bus.fifo_rdata, exp8(0));
    got      = 1'b0;
    prev_sck = bus.sck;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (bus.sck && !prev_sck && (mic_bits % 32) == 8) got = 1'b1;
      prev_sck = bus.sck;
    end
    check("push slot found", 32'(got), 32'd1);
    s = mic_bits / 32;
    pop();
    check("push+pop level", 32'(bus.fifo_level), 32'd16);
    check("push+pop full", 32'(bus.fifo_full), 32'd1);
    for (int k = 1; k < 16; k++) begin
      check("drain order", bus.fifo_rdata, exp8(k));
      pop();
    end
    check("drain last", bus.fifo_rdata, exp8(s));
    pop();
    check("drained level", 32'(bus.fifo_level), 32'd0);
    check("drained full", 32'(bus.fifo_full), 32'd0);
    check("drained rdata", bus.fifo_rdata, 32'd0);

    // Reset mid-slot, then en low/high restart.
    mode            = 0;
    bus.channels    = 2'b01;
    bus.sample_size = 5'd18;
    do_reset();
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (mic_bits == 10) got = 1'b1;
    end
    check("mid-slot reached", 32'(got), 32'd1);
    do_reset();
    check_idle_outputs("mid reset");
    wait_level("post-reset push", 1, 1000, n);
    check("post-reset latency", 32'(n), 32'd186);
    check("post-reset word", bus.fifo_rdata, EXP_L);
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    check("en0 sck", 32'(bus.sck), 32'd0);
    check("en0 ws", 32'(bus.ws), 32'd0);
    check("en0 level", 32'(bus.fifo_level), 32'd1);
    check("en0 rdata", bus.fifo_rdata, EXP_L);
    pop();
    check("en0 pop", 32'(bus.fifo_level), 32'd0);
    bus.en = 1'b1;
    wait_level("restart push", 1, 1000, n);
    check("restart latency", 32'(n), 32'd186);
    check("restart word", bus.fifo_rdata, EXP_L);

    // sample_size 0 never pushes.
    bus.sample_size = 5'd0;
    bus.channels    = 2'b11;
    do_reset();
    repeat (700) @(negedge clk);
    check("size0 level", 32'(bus.fifo_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
